// File: rtl/fluid_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory.
// Reads complete one cycle after grant; a read tag steers readdatavalid to the winner.
module fluid_mem_arbiter #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    output logic                mem_reset_req,
    input  logic [DATA_W-1:0]   mem_readdata,

    output logic                err_both
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic            req0, req1;
    logic            gnt_valid, gnt_idx;
    logic            sel_write;
    logic [BE_W-1:0] sel_be;

    logic rr_last_q, rr_last_d;
    logic tag_valid_q, tag_valid_d;
    logic tag_idx_q, tag_idx_d;
    logic err_both_q, err_both_d;

    always_comb begin
        req0      = m0_read | m0_write;
        req1      = m1_read | m1_write;
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt_valid = 1'b1;
                gnt_idx   = ~rr_last_q;
            end else if (req0) begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b0;
            end else if (req1) begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b1;
            end
        end
    end

    // Read+write together on one master resolves to a write.
    always_comb begin
        mem_address   = m0_address;
        mem_writedata = m0_writedata;
        sel_be        = m0_byteenable;
        sel_write     = m0_write;
        if (gnt_idx) begin
            mem_address   = m1_address;
            mem_writedata = m1_writedata;
            sel_be        = m1_byteenable;
            sel_write     = m1_write;
        end
        mem_chipselect = gnt_valid;
        mem_write      = gnt_valid & sel_write;
        mem_byteenable = sel_write ? sel_be : {BE_W{1'b1}};
    end

    always_comb begin
        rr_last_d   = gnt_valid ? gnt_idx : rr_last_q;
        tag_valid_d = gnt_valid & ~sel_write;
        tag_idx_d   = gnt_idx;
        err_both_d  = err_both_q | (m0_read & m0_write) | (m1_read & m1_write);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q   <= 1'b1;
            tag_valid_q <= 1'b0;
            tag_idx_q   <= 1'b0;
            err_both_q  <= 1'b0;
        end else begin
            rr_last_q   <= rr_last_d;
            tag_valid_q <= tag_valid_d;
            tag_idx_q   <= tag_idx_d;
            err_both_q  <= err_both_d;
        end
    end

    assign m0_waitrequest   = req0 & ~(gnt_valid & ~gnt_idx);
    assign m1_waitrequest   = req1 & ~(gnt_valid & gnt_idx);
    assign m0_readdatavalid = tag_valid_q & ~tag_idx_q;
    assign m1_readdatavalid = tag_valid_q & tag_idx_q;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign mem_clken        = 1'b1;
    assign mem_reset_req    = reset;
    assign err_both         = err_both_q;

endmodule

// File: tb/tb_fluid_mem_arbiter.sv
// Bench for fluid_mem_arbiter: directed table, corner sequences and random traffic
// checked against a transaction-level reference of arbitration and memory contents.
module tb_fluid_mem_arbiter;
    typedef struct {
        logic        rst;
        logic        rd0, wr0;
        logic [14:0] a0;
        logic [7:0]  be0;
        logic [63:0] d0;
        logic        rd1, wr1;
        logic [14:0] a1;
        logic [7:0]  be1;
        logic [63:0] d1;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        w0, w1, cs, we, v0, v1;
        logic [63:0] rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] m0_address, m1_address;
    logic [7:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [63:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [63:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [14:0] mem_address;
    logic [7:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
    logic [63:0] mem_writedata;
    logic [63:0] mem_readdata;
    logic        err_both;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fluid_mem_arbiter #(.ADDR_W(15), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata),
        .err_both(err_both)
    );

    // Environment memory: synchronous RAM with registered read, driven only by the DUT.
    logic [63:0] env_mem [int];
    logic [63:0] env_q = '0;
    assign mem_readdata = env_q;

    always @(posedge clk) begin : env_blk
        logic [63:0] cur;
        if (mem_chipselect && mem_clken) begin
            cur = env_mem.exists(int'(mem_address)) ? env_mem[int'(mem_address)] : 64'd0;
            env_q <= cur;
            if (mem_write) begin
                for (int b = 0; b < 8; b++)
                    if (mem_byteenable[b]) cur[b*8 +: 8] = mem_writedata[b*8 +: 8];
                env_mem[int'(mem_address)] = cur;
            end
        end
    end

    // Reference: last winner, sticky error, expected word contents, read due next cycle.
    logic [63:0] ref_mem [int];
    int          m_last;
    bit          m_err;
    bit          m_init = 1'b0;
    bit          exp_v[2];
    logic [63:0] exp_d;
    int          cur_gnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_rd(input logic [14:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 64'd0;
    endfunction

    task automatic drive(input stim_t s);
        reset = s.rst;
        m0_read = s.rd0; m0_write = s.wr0; m0_address = s.a0;
        m0_byteenable = s.be0; m0_writedata = s.d0;
        m1_read = s.rd1; m1_write = s.wr1; m1_address = s.a1;
        m1_byteenable = s.be1; m1_writedata = s.d1;
    endtask

    task automatic model_check();
        bit          r0, r1, wsel;
        logic [14:0] asel;
        logic [7:0]  besel;
        logic [63:0] dsel;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (reset) cur_gnt = -1;
        else if (r0 && r1) cur_gnt = 1 - m_last;
        else if (r0) cur_gnt = 0;
        else if (r1) cur_gnt = 1;
        else cur_gnt = -1;
        check("m0_waitrequest", 64'(m0_waitrequest), 64'(r0 && cur_gnt != 0));
        check("m1_waitrequest", 64'(m1_waitrequest), 64'(r1 && cur_gnt != 1));
        check("mem_chipselect", 64'(mem_chipselect), 64'(cur_gnt >= 0));
        check("mem_clken", 64'(mem_clken), 64'd1);
        check("mem_reset_req", 64'(mem_reset_req), 64'(reset));
        wsel = (cur_gnt == 1) ? m1_write : m0_write;
        check("mem_write", 64'(mem_write), 64'(cur_gnt >= 0 && wsel));
        if (cur_gnt >= 0) begin
            asel  = (cur_gnt == 1) ? m1_address : m0_address;
            besel = (cur_gnt == 1) ? m1_byteenable : m0_byteenable;
            dsel  = (cur_gnt == 1) ? m1_writedata : m0_writedata;
            check("mem_address", 64'(mem_address), 64'(asel));
            check("mem_byteenable", 64'(mem_byteenable), 64'(wsel ? besel : 8'hFF));
            check("mem_writedata", mem_writedata, dsel);
        end
        if (m_init) begin
            check("m0_readdatavalid", 64'(m0_readdatavalid), 64'(exp_v[0]));
            check("m1_readdatavalid", 64'(m1_readdatavalid), 64'(exp_v[1]));
            if (exp_v[0]) check("m0_readdata", m0_readdata, exp_d);
            if (exp_v[1]) check("m1_readdata", m1_readdata, exp_d);
            check("err_both", 64'(err_both), 64'(m_err));
        end
    endtask

    task automatic model_advance();
        logic [63:0] w;
        bit          wr;
        logic [14:0] a;
        exp_v[0] = 1'b0;
        exp_v[1] = 1'b0;
        if (reset) begin
            m_last = 1;
            m_err  = 1'b0;
            m_init = 1'b1;
            return;
        end
        m_err = m_err | (m0_read & m0_write) | (m1_read & m1_write);
        if (cur_gnt < 0) return;
        m_last = cur_gnt;
        wr = (cur_gnt == 1) ? m1_write : m0_write;
        a  = (cur_gnt == 1) ? m1_address : m0_address;
        if (wr) begin
            w = ref_rd(a);
            for (int b = 0; b < 8; b++) begin
                if (cur_gnt == 1 && m1_byteenable[b]) w[b*8 +: 8] = m1_writedata[b*8 +: 8];
                if (cur_gnt == 0 && m0_byteenable[b]) w[b*8 +: 8] = m0_writedata[b*8 +: 8];
            end
            ref_mem[int'(a)] = w;
        end else begin
            exp_v[cur_gnt] = 1'b1;
            exp_d = ref_rd(a);
        end
    endtask

    // Drive in the cycle body, then sample at the falling edge.
    task automatic start_cycle(input stim_t s);
        @(posedge clk);
        #1;
        drive(s);
        #4;
        model_check();
    endtask

    task automatic cycle(input stim_t s);
        start_cycle(s);
        model_advance();
    endtask

    function automatic stim_t st(input bit rst,
                                 input bit rd0, input bit wr0, input logic [14:0] a0,
                                 input logic [7:0] be0, input logic [63:0] d0,
                                 input bit rd1, input bit wr1, input logic [14:0] a1,
                                 input logic [7:0] be1, input logic [63:0] d1);
        stim_t s;
        s.rst = rst; s.rd0 = rd0; s.wr0 = wr0; s.a0 = a0; s.be0 = be0; s.d0 = d0;
        s.rd1 = rd1; s.wr1 = wr1; s.a1 = a1; s.be1 = be1; s.d1 = d1;
        return s;
    endfunction

    function automatic vec_t vv(input stim_t s, input bit w0, input bit w1, input bit cs,
                                input bit we, input bit v0, input bit v1,
                                input logic [63:0] rdata);
        vec_t v;
        v.s = s; v.w0 = w0; v.w1 = w1; v.cs = cs; v.we = we; v.v0 = v0; v.v1 = v1;
        v.rdata = rdata;
        return v;
    endfunction

    function automatic logic [14:0] rand_addr();
        return ($urandom_range(0, 4) == 0) ? 15'h7FFF : 15'($urandom_range(0, 7));
    endfunction

    vec_t  tbl[$];
    stim_t idle, s;

    initial begin
        idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state: no grants, requesters stalled, nothing valid.
        cycle(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_cycle(st(1, 1, 0, 15'h1, 8'h0, 64'h0, 1, 0, 15'h2, 8'h0, 64'h0));
        check("reset m0_waitrequest", 64'(m0_waitrequest), 64'd1);
        check("reset m1_waitrequest", 64'(m1_waitrequest), 64'd1);
        check("reset chipselect", 64'(mem_chipselect), 64'd0);
        check("reset err_both", 64'(err_both), 64'd0);
        model_advance();

        // Write/read back, alternation after reset, byte lanes, top-of-range address.
        tbl.push_back(vv(st(0, 0, 1, 15'h10, 8'hFF, 64'h1122334455667788, 0, 0, 0, 0, 0),
                         0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(vv(st(0, 1, 0, 15'h10, 8'h00, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(vv(idle, 0, 0, 0, 0, 1, 0, 64'h1122334455667788));
        tbl.push_back(vv(st(1, 1, 0, 15'h10, 0, 0, 1, 0, 15'h20, 0, 0), 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(vv(st(0, 1, 0, 15'h10, 0, 0, 1, 0, 15'h20, 0, 0),
                             i % 2, (i + 1) % 2, 1, 0, (i > 0) && (i % 2 == 1),
                             (i > 0) && (i % 2 == 0),
                             (i % 2 == 1) ? 64'h1122334455667788 : 64'h0));
        tbl.push_back(vv(idle, 0, 0, 0, 0, 0, 1, 64'h0));
        tbl.push_back(vv(st(0, 0, 0, 0, 0, 0, 0, 1, 15'h30, 8'hFF, 64'hFFFFFFFFFFFFFFFF),
                         0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(vv(st(0, 0, 0, 0, 0, 0, 0, 1, 15'h30, 8'h0F, 64'h0),
                         0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(vv(st(0, 0, 0, 0, 0, 0, 1, 0, 15'h30, 0, 0), 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(vv(idle, 0, 0, 0, 0, 0, 1, 64'hFFFFFFFF00000000));
        tbl.push_back(vv(st(0, 0, 1, 15'h7FFF, 8'hFF, 64'hA5, 0, 0, 0, 0, 0),
                         0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(vv(st(0, 0, 0, 0, 0, 0, 1, 0, 15'h7FFF, 0, 0), 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(vv(idle, 0, 0, 0, 0, 0, 1, 64'hA5));

        foreach (tbl[i]) begin
            start_cycle(tbl[i].s);
            check($sformatf("tbl%0d m0_waitrequest", i), 64'(m0_waitrequest), 64'(tbl[i].w0));
            check($sformatf("tbl%0d m1_waitrequest", i), 64'(m1_waitrequest), 64'(tbl[i].w1));
            check($sformatf("tbl%0d chipselect", i), 64'(mem_chipselect), 64'(tbl[i].cs));
            check($sformatf("tbl%0d mem_write", i), 64'(mem_write), 64'(tbl[i].we));
            check($sformatf("tbl%0d m0_rdv", i), 64'(m0_readdatavalid), 64'(tbl[i].v0));
            check($sformatf("tbl%0d m1_rdv", i), 64'(m1_readdatavalid), 64'(tbl[i].v1));
            if (tbl[i].v0) check($sformatf("tbl%0d m0_rdata", i), m0_readdata, tbl[i].rdata);
            if (tbl[i].v1) check($sformatf("tbl%0d m1_rdata", i), m1_readdata, tbl[i].rdata);
            model_advance();
        end

        // m1 read+write together: performed as a write, error sticky until reset.
        start_cycle(st(0, 0, 0, 0, 0, 0, 1, 1, 15'h40, 8'hFF, 64'hDEAD));
        check("both mem_write", 64'(mem_write), 64'd1);
        check("both err_before", 64'(err_both), 64'd0);
        model_advance();
        for (int i = 0; i < 3; i++) begin
            start_cycle(idle);
            check("both err_sticky", 64'(err_both), 64'd1);
            model_advance();
        end
        start_cycle(st(0, 0, 0, 0, 0, 0, 1, 0, 15'h40, 0, 0));
        model_advance();
        start_cycle(idle);
        check("both rdv", 64'(m1_readdatavalid), 64'd1);
        check("both rdata", m1_readdata, 64'hDEAD);
        model_advance();

        // Reset over an m1 read: no valid afterwards, m0 wins first contention.
        cycle(st(0, 1, 0, 15'h1, 0, 0, 0, 0, 0, 0, 0));
        start_cycle(st(1, 0, 0, 0, 0, 0, 1, 0, 15'h40, 0, 0));
        check("rst m1_waitrequest", 64'(m1_waitrequest), 64'd1);
        model_advance();
        start_cycle(st(0, 1, 0, 15'h1, 0, 0, 1, 0, 15'h40, 0, 0));
        check("rst m1_rdv", 64'(m1_readdatavalid), 64'd0);
        check("rst err_cleared", 64'(err_both), 64'd0);
        check("rst m0 wins", 64'(m0_waitrequest), 64'd0);
        check("rst m1 waits", 64'(m1_waitrequest), 64'd1);
        model_advance();

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            s = idle;
            s.rst = ($urandom_range(0, 39) == 0);
            s.rd0 = ($urandom_range(0, 2) != 0);
            s.wr0 = ($urandom_range(0, 2) == 0) && ($urandom_range(0, 7) == 0 || !s.rd0);
            s.rd1 = ($urandom_range(0, 2) != 0);
            s.wr1 = ($urandom_range(0, 2) == 0) && ($urandom_range(0, 7) == 0 || !s.rd1);
            s.a0 = rand_addr();
            s.a1 = rand_addr();
            s.be0 = 8'($urandom);
            s.be1 = 8'($urandom);
            s.d0 = {$urandom, $urandom};
            s.d1 = {$urandom, $urandom};
            cycle(s);
        end
        cycle(idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
